rename_unit: RTL and testbench
==============================

RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 SHALL have parameters: NUM_AREG, default 64, number of architectural registers (x0-x31, f0-f31); NUM_PREG, default 128, number of physical registers.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: rn_valid  in  1  rename request; rn_A_rs1, rn_A_rs2  in  6  source arch regs; rn_A_rd  in  6  destination arch reg; rn_rd_write  in  1  instruction writes rd.
REQ-004 SHALL have ports: rn_ready  out  1  request accepted; rn_P_rs1, rn_P_rs2  out  7  source phys regs; rn_P_rd_new  out  7  allocated phys reg; rn_P_rd_old  out  7  previous mapping of rd.
REQ-005 SHALL have ports: commit_wb_en  in  1  retiring instruction wrote a phys reg; commit_P_rd_old  in  7  phys reg to free.
REQ-006 SHALL have ports: rollback_en_0, rollback_en_1  in  1  undo youngest / next-youngest entry; rollback_A_rd_0/1  in  6; rollback_P_rd_old_0/1  in  7; rollback_P_rd_new_0/1  in  7.
REQ-007 SHALL have ports: stall  in  1  recovery in progress; free_count  out  7  free-list occupancy; fl_error  out  1  sticky free-list overflow/underflow flag.

Function
REQ-008 SHALL hold a map table of NUM_AREG 7-bit entries and a circular free-list FIFO of NUM_PREG-NUM_AREG (64) 7-bit entries with 6-bit head/tail and 7-bit count.
REQ-009 SHALL drive rn_P_rs1/rn_P_rs2 combinationally from the map as it stands before this cycle's writes (no same-cycle bypass from rd).
REQ-010 SHALL treat a request as "allocating" when rn_rd_write=1 and rn_A_rd!=0.
REQ-011 SHALL drive rn_ready = !stall && !rollback_en_0 && !rollback_en_1 && (!allocating || count!=0); a push in the same cycle SHALL NOT make an empty list ready.
REQ-012 SHALL, for an allocating request, drive rn_P_rd_new = free-list head entry and rn_P_rd_old = map[rn_A_rd]; otherwise drive both 0.
REQ-013 SHALL, on rn_valid && rn_ready && allocating, pop the head and write map[rn_A_rd] <= rn_P_rd_new at the clock edge.
REQ-014 SHALL keep map[0] = 0 permanently; writes to entry 0 SHALL be ignored.
REQ-015 SHALL, on rollback_en_0, write map[rollback_A_rd_0] <= rollback_P_rd_old_0 and push rollback_P_rd_new_0, if rollback_P_rd_new_0!=0.
REQ-016 SHALL, on rollback_en_1, do the same with port 1; if both ports target the same A_rd, port 1 (older) SHALL win the map write.
REQ-017 SHALL, on commit_wb_en with commit_P_rd_old!=0, push commit_P_rd_old.
REQ-018 SHALL accept up to three pushes per cycle, written to tail, tail+1, tail+2 (mod 64) in order commit, rollback 0, rollback 1, skipping absent pushes without gaps.
REQ-019 SHALL update count = count + pushes - pop each cycle; pointers wrap modulo 64.
REQ-020 SHALL set fl_error sticky when count + pushes - pop > 64, or a pop occurs with count=0; the offending push/pop SHALL be dropped.
REQ-021 SHALL drive free_count = count (registered).
REQ-022 SHALL allow commit pushes concurrently with a rename pop or with rollbacks.

Reset
REQ-023 SHALL on rst set map[i] = i for i = 0..63.
REQ-024 SHALL on rst load free-list entry k = 64+k for k = 0..63, head=0, tail=0, count=64, fl_error=0.
REQ-025 SHALL give rst priority over all same-cycle requests; a rename, commit, or rollback presented during reset SHALL have no effect.

Verification
REQ-026 Reset then rename A_rd=5, rd_write=1 -> rn_P_rd_new=64, rn_P_rd_old=5; next cycle map[5]=64, free_count=63.
REQ-027 Rename A_rd=5, then rename rs1=5, A_rd=5 -> second rn_P_rs1=64, rn_P_rd_new=65, rn_P_rd_old=64.
REQ-028 64 allocating renames then another -> rn_ready=0; same cycle commit_P_rd_old=3 -> rn_ready still 0; next cycle free_count=1, rn_ready=1, next alloc returns 3.
REQ-029 After renames 7->64 then 7->65, assert rollback_en_0 (A_rd 7, old 64, new 65) and rollback_en_1 (A_rd 7, old 7, new 64) together -> map[7]=7, free_count +2, rn_ready=0 that cycle.
REQ-030 Rename A_rd=0 or rd_write=0 -> rn_P_rd_new=0, rn_P_rd_old=0, free_count unchanged, map[0]=0.
REQ-031 Commit pushes with free_count=64 -> fl_error=1, free_count stays 64; fl_error holds until rst.

Source files
------------

// File: rtl/rename_unit.sv
// Register rename unit: an architectural-to-physical map table plus a circular
// free list, with rename pops, commit frees and two-entry rollback.
module rename_unit #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rn_valid,
  input  logic [5:0] rn_A_rs1,
  input  logic [5:0] rn_A_rs2,
  input  logic [5:0] rn_A_rd,
  input  logic       rn_rd_write,
  output logic       rn_ready,
  output logic [6:0] rn_P_rs1,
  output logic [6:0] rn_P_rs2,
  output logic [6:0] rn_P_rd_new,
  output logic [6:0] rn_P_rd_old,
  input  logic       commit_wb_en,
  input  logic [6:0] commit_P_rd_old,
  input  logic       rollback_en_0,
  input  logic       rollback_en_1,
  input  logic [5:0] rollback_A_rd_0,
  input  logic [5:0] rollback_A_rd_1,
  input  logic [6:0] rollback_P_rd_old_0,
  input  logic [6:0] rollback_P_rd_old_1,
  input  logic [6:0] rollback_P_rd_new_0,
  input  logic [6:0] rollback_P_rd_new_1,
  input  logic       stall,
  output logic [6:0] free_count,
  output logic       fl_error
);

  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;

  logic [6:0] map [NUM_AREG];
  logic [6:0] fl  [FL_DEPTH];
  logic [5:0] head;
  logic [5:0] tail;
  logic [6:0] count;
  logic       fl_err_q;

  logic       allocating;
  logic       pop_req;
  logic       pop;
  logic       underflow;
  logic       overflow;
  logic       push_c;
  logic       push_0;
  logic       push_1;
  logic [1:0] n_push;
  logic [1:0] n_acc;
  logic [6:0] push_val [3];
  logic [7:0] room;
  logic [6:0] count_next;

  assign allocating = rn_rd_write && (rn_A_rd != 6'd0);

  // A push landing this cycle cannot make an empty list ready; only the registered count matters.
  assign rn_ready = !stall && !rollback_en_0 && !rollback_en_1 &&
                    (!allocating || (count != 7'd0));

  assign rn_P_rs1    = map[rn_A_rs1];
  assign rn_P_rs2    = map[rn_A_rs2];
  assign rn_P_rd_new = allocating ? fl[head] : 7'd0;
  assign rn_P_rd_old = allocating ? map[rn_A_rd] : 7'd0;

  assign pop_req   = rn_valid && rn_ready && allocating;
  assign underflow = pop_req && (count == 7'd0);
  assign pop       = pop_req && !underflow;

  assign push_c = commit_wb_en  && (commit_P_rd_old     != 7'd0);
  assign push_0 = rollback_en_0 && (rollback_P_rd_new_0 != 7'd0);
  assign push_1 = rollback_en_1 && (rollback_P_rd_new_1 != 7'd0);

  // Pack the present pushes into consecutive slots, in commit / rollback 0 / rollback 1 order.
  // NOTE: blocking assignments here are deliberate; n_push is a running slot index that
  // later statements in the same block must see updated.
  always_comb begin
    n_push      = 2'd0;
    push_val[0] = 7'd0;
    push_val[1] = 7'd0;
    push_val[2] = 7'd0;
    if (push_c) begin
      push_val[n_push] = commit_P_rd_old;
      n_push           = n_push + 2'd1;
    end
    if (push_0) begin
      push_val[n_push] = rollback_P_rd_new_0;
      n_push           = n_push + 2'd1;
    end
    if (push_1) begin
      push_val[n_push] = rollback_P_rd_new_1;
      n_push           = n_push + 2'd1;
    end
  end

  // Slots free after this cycle's pop; pushes beyond that are dropped and flagged.
  assign room       = 8'(FL_DEPTH) - {1'b0, count} + {7'd0, pop};
  assign overflow   = ({6'd0, n_push} > room);
  assign n_acc      = overflow ? room[1:0] : n_push;
  assign count_next = count + {5'd0, n_acc} - {6'd0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both arrays are reset because their power-on contents are architectural
      // (identity map, preloaded free list), so they build as flops rather than RAM.
      for (int i = 0; i < NUM_AREG; i++) map[i] <= 7'(i);
      for (int k = 0; k < FL_DEPTH; k++) fl[k] <= 7'(NUM_AREG + k);
      head     <= 6'd0;
      tail     <= 6'd0;
      count    <= 7'(FL_DEPTH);
      fl_err_q <= 1'b0;
    end else begin
      if (pop) begin
        map[rn_A_rd] <= fl[head];
        head         <= head + 6'd1;
      end
      // NOTE: when both rollback ports name the same register, the later
      // non-blocking write (port 1, the older entry) is the one that sticks.
      if (rollback_en_0 && (rollback_A_rd_0 != 6'd0))
        map[rollback_A_rd_0] <= rollback_P_rd_old_0;
      if (rollback_en_1 && (rollback_A_rd_1 != 6'd0))
        map[rollback_A_rd_1] <= rollback_P_rd_old_1;
      for (int s = 0; s < 3; s++) begin
        if (2'(s) < n_acc) fl[tail + 6'(s)] <= push_val[s];
      end
      tail  <= tail + {4'd0, n_acc};
      count <= count_next;
      if (overflow || underflow) fl_err_q <= 1'b1;
    end
  end

  assign free_count = count;
  assign fl_error   = fl_err_q;

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: the driver queues hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       rn_valid;
  logic [5:0] rn_A_rs1, rn_A_rs2, rn_A_rd;
  logic       rn_rd_write;
  logic       rn_ready;
  logic [6:0] rn_P_rs1, rn_P_rs2, rn_P_rd_new, rn_P_rd_old;
  logic       commit_wb_en;
  logic [6:0] commit_P_rd_old;
  logic       rollback_en_0, rollback_en_1;
  logic [5:0] rollback_A_rd_0, rollback_A_rd_1;
  logic [6:0] rollback_P_rd_old_0, rollback_P_rd_old_1;
  logic [6:0] rollback_P_rd_new_0, rollback_P_rd_new_1;
  logic       stall;
  logic [6:0] free_count;
  logic       fl_error;

  rename_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .rn_valid            (rn_valid),
    .rn_A_rs1            (rn_A_rs1),
    .rn_A_rs2            (rn_A_rs2),
    .rn_A_rd             (rn_A_rd),
    .rn_rd_write         (rn_rd_write),
    .rn_ready            (rn_ready),
    .rn_P_rs1            (rn_P_rs1),
    .rn_P_rs2            (rn_P_rs2),
    .rn_P_rd_new         (rn_P_rd_new),
    .rn_P_rd_old         (rn_P_rd_old),
    .commit_wb_en        (commit_wb_en),
    .commit_P_rd_old     (commit_P_rd_old),
    .rollback_en_0       (rollback_en_0),
    .rollback_en_1       (rollback_en_1),
    .rollback_A_rd_0     (rollback_A_rd_0),
    .rollback_A_rd_1     (rollback_A_rd_1),
    .rollback_P_rd_old_0 (rollback_P_rd_old_0),
    .rollback_P_rd_old_1 (rollback_P_rd_old_1),
    .rollback_P_rd_new_0 (rollback_P_rd_new_0),
    .rollback_P_rd_new_1 (rollback_P_rd_new_1),
    .stall               (stall),
    .free_count          (free_count),
    .fl_error            (fl_error)
  );

  always #5 clk = ~clk;

  localparam bit [6:0] C_RDY = 7'h01, C_RS1 = 7'h02, C_RS2 = 7'h04, C_NEW = 7'h08,
                       C_OLD = 7'h10, C_FC  = 7'h20, C_ERR = 7'h40;

  typedef struct {
    string      name;
    bit   [6:0] care;
    logic       ready;
    logic [6:0] rs1, rs2, rd_new, rd_old, fc;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic exp_push(string n, bit [6:0] care, logic rdy, logic [6:0] rs1,
                          logic [6:0] rs2, logic [6:0] nw, logic [6:0] old,
                          logic [6:0] fc, logic err);
    exp_t e;
    e.name = n; e.care = care; e.ready = rdy; e.rs1 = rs1; e.rs2 = rs2;
    e.rd_new = nw; e.rd_old = old; e.fc = fc; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.care[0]) check({e.name, "/ready"},  32'(rn_ready),    32'(e.ready));
      if (e.care[1]) check({e.name, "/rs1"},    32'(rn_P_rs1),    32'(e.rs1));
      if (e.care[2]) check({e.name, "/rs2"},    32'(rn_P_rs2),    32'(e.rs2));
      if (e.care[3]) check({e.name, "/rd_new"}, 32'(rn_P_rd_new), 32'(e.rd_new));
      if (e.care[4]) check({e.name, "/rd_old"}, 32'(rn_P_rd_old), 32'(e.rd_old));
      if (e.care[5]) check({e.name, "/fc"},     32'(free_count),  32'(e.fc));
      if (e.care[6]) check({e.name, "/err"},    32'(fl_error),    32'(e.err));
    end
  end

  task automatic clr();
    rst = 1'b0; rn_valid = 1'b0; rn_A_rs1 = 6'd0; rn_A_rs2 = 6'd0; rn_A_rd = 6'd0;
    rn_rd_write = 1'b0; commit_wb_en = 1'b0; commit_P_rd_old = 7'd0;
    rollback_en_0 = 1'b0; rollback_en_1 = 1'b0;
    rollback_A_rd_0 = 6'd0; rollback_A_rd_1 = 6'd0;
    rollback_P_rd_old_0 = 7'd0; rollback_P_rd_old_1 = 7'd0;
    rollback_P_rd_new_0 = 7'd0; rollback_P_rd_new_1 = 7'd0;
    stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic ren(logic [5:0] rd, logic [5:0] rs1, logic [5:0] rs2, logic wr);
    rn_valid = 1'b1; rn_A_rd = rd; rn_A_rs1 = rs1; rn_A_rs2 = rs2; rn_rd_write = wr;
  endtask

  task automatic look(logic [5:0] rs1, logic [5:0] rs2);
    rn_A_rs1 = rs1; rn_A_rs2 = rs2;
  endtask

  task automatic commit(logic [6:0] p);
    commit_wb_en = 1'b1; commit_P_rd_old = p;
  endtask

  task automatic rb0(logic [5:0] a, logic [6:0] old, logic [6:0] nw);
    rollback_en_0 = 1'b1; rollback_A_rd_0 = a; rollback_P_rd_old_0 = old; rollback_P_rd_new_0 = nw;
  endtask

  task automatic rb1(logic [5:0] a, logic [6:0] old, logic [6:0] nw);
    rollback_en_1 = 1'b1; rollback_A_rd_1 = a; rollback_P_rd_old_1 = old; rollback_P_rd_new_1 = nw;
  endtask

  logic [6:0] drain_new [4] = '{7'd11, 7'd20, 7'd21, 7'd22};

  initial begin
    clr();
    rst = 1'b1;

    // Reset with rename/commit/rollback traffic present: traffic must be ignored.
    tick(); rst = 1'b1; ren(6'd5, 6'd5, 6'd5, 1'b1); commit(7'd9); rb0(6'd9, 7'd100, 7'd101);
    tick(); look(6'd9, 6'd63);
    exp_push("reset", C_RDY|C_RS1|C_RS2|C_NEW|C_OLD|C_FC|C_ERR,
             1'b1, 7'd9, 7'd63, 7'd0, 7'd0, 7'd64, 1'b0);
    tick(); look(6'd5, 6'd0);
    exp_push("reset_map", C_RS1|C_RS2, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);

    // Basic allocation and read-before-write of the same register.
    tick(); ren(6'd5, 6'd5, 6'd0, 1'b1);
    exp_push("ren5_a", C_RDY|C_RS1|C_NEW|C_OLD|C_FC, 1'b1, 7'd5, 7'd0, 7'd64, 7'd5, 7'd64, 1'b0);
    tick(); ren(6'd5, 6'd5, 6'd0, 1'b1);
    exp_push("ren5_b", C_RDY|C_RS1|C_NEW|C_OLD|C_FC, 1'b1, 7'd64, 7'd0, 7'd65, 7'd64, 7'd63, 1'b0);
    tick(); ren(6'd0, 6'd5, 6'd0, 1'b1);
    exp_push("ren_x0", C_RDY|C_RS1|C_NEW|C_OLD|C_FC, 1'b1, 7'd65, 7'd0, 7'd0, 7'd0, 7'd62, 1'b0);
    tick(); ren(6'd5, 6'd0, 6'd5, 1'b0);
    exp_push("ren_nowr", C_RDY|C_RS1|C_RS2|C_NEW|C_OLD|C_FC,
             1'b1, 7'd0, 7'd65, 7'd0, 7'd0, 7'd62, 1'b0);
    tick(); ren(6'd6, 6'd6, 6'd0, 1'b1); stall = 1'b1;
    exp_push("stall", C_RDY|C_RS1|C_FC, 1'b0, 7'd6, 7'd0, 7'd0, 7'd0, 7'd62, 1'b0);
    tick(); look(6'd6, 6'd5);
    exp_push("after_stall", C_RS1|C_RS2|C_FC, 1'b1, 7'd6, 7'd65, 7'd0, 7'd0, 7'd62, 1'b0);

    // Dual rollback on the same register: port 1 restores the original mapping.
    tick(); rst = 1'b1;
    tick(); ren(6'd7, 6'd7, 6'd0, 1'b1);
    exp_push("rb_ren1", C_RDY|C_NEW|C_OLD|C_FC, 1'b1, 7'd0, 7'd0, 7'd64, 7'd7, 7'd64, 1'b0);
    tick(); ren(6'd7, 6'd7, 6'd0, 1'b1);
    exp_push("rb_ren2", C_RDY|C_RS1|C_NEW|C_OLD|C_FC, 1'b1, 7'd64, 7'd0, 7'd65, 7'd64, 7'd63, 1'b0);
    tick(); ren(6'd9, 6'd0, 6'd0, 1'b1);
    rb0(6'd7, 7'd64, 7'd65); rb1(6'd7, 7'd7, 7'd64);
    exp_push("rb_both", C_RDY|C_FC, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd62, 1'b0);
    tick(); look(6'd7, 6'd9);
    exp_push("rb_after", C_RDY|C_RS1|C_RS2|C_FC, 1'b1, 7'd7, 7'd9, 7'd0, 7'd0, 7'd64, 1'b0);
    tick(); ren(6'd8, 6'd0, 6'd0, 1'b1);
    exp_push("rb_next", C_RDY|C_NEW|C_OLD|C_FC, 1'b1, 7'd0, 7'd0, 7'd66, 7'd8, 7'd64, 1'b0);

    // Drain the whole free list, then exercise the empty boundary.
    tick(); rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(); ren(6'(1 + i % 31), 6'd0, 6'd0, 1'b1);
      exp_push("fill", C_RDY|C_NEW|C_FC, 1'b1, 7'd0, 7'd0, 7'(64 + i), 7'd0, 7'(64 - i), 1'b0);
    end
    tick(); ren(6'd1, 6'd0, 6'd0, 1'b1); commit(7'd3);
    exp_push("empty_push", C_RDY|C_FC|C_ERR, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    tick(); ren(6'd2, 6'd0, 6'd0, 1'b1);
    exp_push("refill", C_RDY|C_NEW|C_FC, 1'b1, 7'd0, 7'd0, 7'd3, 7'd0, 7'd1, 1'b0);
    tick(); commit(7'd10);
    exp_push("drained", C_RDY|C_FC, 1'b1, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    tick(); ren(6'd3, 6'd0, 6'd0, 1'b1); commit(7'd11);
    exp_push("pop_push", C_RDY|C_NEW|C_FC, 1'b1, 7'd0, 7'd0, 7'd10, 7'd0, 7'd1, 1'b0);
    tick(); ren(6'd4, 6'd0, 6'd0, 1'b1); commit(7'd20);
    rb0(6'd4, 7'd4, 7'd21); rb1(6'd6, 7'd6, 7'd22);
    exp_push("triple", C_RDY|C_NEW|C_FC, 1'b0, 7'd0, 7'd0, 7'd11, 7'd0, 7'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); ren(6'd4, 6'd0, 6'd0, 1'b1);
      exp_push("triple_pop", C_RDY|C_NEW|C_FC, 1'b1, 7'd0, 7'd0, drain_new[i], 7'd0, 7'(4 - i), 1'b0);
    end
    tick(); rb0(6'd4, 7'd4, 7'd0);
    exp_push("rb_zero", C_FC, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    tick(); commit(7'd30); rb1(6'd6, 7'd6, 7'd31);
    exp_push("gap_push", C_FC, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    tick(); ren(6'd5, 6'd0, 6'd0, 1'b1);
    exp_push("gap_pop0", C_RDY|C_NEW|C_FC, 1'b1, 7'd0, 7'd0, 7'd30, 7'd0, 7'd2, 1'b0);
    tick(); ren(6'd5, 6'd0, 6'd0, 1'b1);
    exp_push("gap_pop1", C_RDY|C_NEW|C_FC|C_ERR, 1'b1, 7'd0, 7'd0, 7'd31, 7'd0, 7'd1, 1'b0);

    // Full-list boundary: push+pop is legal, a lone push overflows.
    tick(); rst = 1'b1;
    tick(); ren(6'd3, 6'd0, 6'd0, 1'b1); commit(7'd40);
    exp_push("full_swap", C_RDY|C_NEW|C_FC|C_ERR, 1'b1, 7'd0, 7'd0, 7'd64, 7'd0, 7'd64, 1'b0);
    tick(); commit(7'd5);
    exp_push("full_push", C_FC|C_ERR, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd64, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_push("overflow", C_FC|C_ERR, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd64, 1'b1);
    end
    tick(); rst = 1'b1;
    tick();
    exp_push("err_clear", C_FC|C_ERR, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd64, 1'b0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
